// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    localparam int unsigned word_width = 8;

    typedef logic [word_width-1:0] word_t;

    // Pointer width: one extra MSB distinguishes full from empty when low bits match.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port, one combinational read port.
module fifo_mem #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 16
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(depth)-1:0] waddr,
    input  logic [width-1:0]         wdata,
    input  logic [$clog2(depth)-1:0] raddr,
    output logic [width-1:0]         rdata
);

    logic [width-1:0] mem [depth];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read gives first-word-fall-through at the head pointer.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive-side word FIFO between uart_rx and the consumer stream.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned width             = 8,
    parameter int unsigned depth             = 16,
    parameter int unsigned almost_full_level = 12
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [width-1:0]            rx_data,
    input  logic                        rx_ready,
    output logic                        rx_can_receive_next_word,
    output logic [width-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    input  logic                        flush,
    output logic [ptr_width(depth)-1:0] level,
    output logic                        empty,
    output logic                        full,
    output logic                        almost_full
);

    localparam int unsigned pw = ptr_width(depth);
    localparam int unsigned aw = pw - 1;
    localparam logic [pw-1:0] af_level = pw'(almost_full_level);

    logic [pw-1:0] wr_ptr_q, wr_ptr_d;
    logic [pw-1:0] rd_ptr_q, rd_ptr_d;
    logic          push, pop, we;

    // Status decodes come only from registered pointers, so out_ready never reaches
    // rx_can_receive_next_word combinationally.
    always_comb begin
        full        = (wr_ptr_q[aw-1:0] == rd_ptr_q[aw-1:0]) &&
                      (wr_ptr_q[aw] != rd_ptr_q[aw]);
        empty       = (wr_ptr_q == rd_ptr_q);
        level       = wr_ptr_q - rd_ptr_q;
        almost_full = (level >= af_level);
        out_valid   = !empty;
        rx_can_receive_next_word = !full && !reset;

        push = rx_ready && rx_can_receive_next_word;
        pop  = out_valid && out_ready;
        // A word offered during flush is dropped, so keep it out of storage too.
        we   = push && !flush;

        wr_ptr_d = wr_ptr_q + {{(pw-1){1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{(pw-1){1'b0}}, pop};
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    fifo_mem #(
        .width (width),
        .depth (depth)
    ) u_mem (
        .clock (clock),
        .we    (we),
        .waddr (wr_ptr_q[aw-1:0]),
        .wdata (rx_data),
        .raddr (rd_ptr_q[aw-1:0]),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench: directed vector table plus a scoreboarded wrap-around stream.
module tb_uart_rx_buffer;
    import uart_pkg::*;

    logic       clock;
    logic       reset;
    word_t      rx_data;
    logic       rx_ready;
    logic       rx_can_receive_next_word;
    word_t      out_data;
    logic       out_valid;
    logic       out_ready;
    logic       flush;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       almost_full;

    int n_total = 0;
    int n_pass  = 0;

    uart_rx_buffer #(
        .width             (8),
        .depth             (16),
        .almost_full_level (12)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .rx_data                  (rx_data),
        .rx_ready                 (rx_ready),
        .rx_can_receive_next_word (rx_can_receive_next_word),
        .out_data                 (out_data),
        .out_valid                (out_valid),
        .out_ready                (out_ready),
        .flush                    (flush),
        .level                    (level),
        .empty                    (empty),
        .full                     (full),
        .almost_full              (almost_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs applied for one cycle, expected outputs seen just after that edge.
    typedef struct {
        logic  rst;
        logic  rdy;
        word_t d;
        logic  ordy;
        logic  fl;
        logic  ev;
        word_t ed;
        int    el;
        logic  eaf;
        logic  ecan;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic rdy, input int d,
                                input logic ordy, input logic fl, input logic ev,
                                input int ed, input int el, input logic eaf,
                                input logic ecan);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.d = word_t'(d); v.ordy = ordy; v.fl = fl;
        v.ev = ev; v.ed = word_t'(ed); v.el = el; v.eaf = eaf; v.ecan = ecan;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    initial begin
        int    idx, got, mlevel, cyc;
        logic  push_m, pop_m;
        word_t q[$];

        reset = 1'b1; rx_ready = 1'b0; rx_data = '0; out_ready = 1'b0; flush = 1'b0;

        // Reset held two cycles, then idle.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        // Single word latency, then pop back to empty.
        vecs.push_back(mk(0, 1, 'hA5, 0, 0, 1, 'hA5, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        // Fill 0x00..0x0F; almost_full on the 12th, full on the 16th.
        for (int i = 0; i < 16; i++) begin
            vecs.push_back(mk(0, 1, i, 0, 0, 1, 'h00, i + 1, (i + 1 >= 12), (i + 1 != 16)));
        end
        // 0x10 offered while full: refused.
        vecs.push_back(mk(0, 1, 'h10, 0, 0, 1, 'h00, 16, 1, 0));
        // Pop at full: 0x00 leaves, 0x10 not yet taken.
        vecs.push_back(mk(0, 1, 'h10, 1, 0, 1, 'h01, 15, 1, 1));
        // 0x10 accepted the next cycle.
        vecs.push_back(mk(0, 1, 'h10, 0, 0, 1, 'h01, 16, 1, 0));
        // Drain: heads 0x02..0x10 in order, then empty.
        for (int k = 1; k <= 16; k++) begin
            vecs.push_back(mk(0, 0, 0, 1, 0, (k != 16), 1 + k, 16 - k, (16 - k >= 12), 1));
        end
        // Empty with push and pop requested: push only.
        vecs.push_back(mk(0, 1, 'h88, 1, 0, 1, 'h88, 1, 0, 1));
        // Simultaneous push and pop at level 1.
        vecs.push_back(mk(0, 1, 'h77, 1, 0, 1, 'h77, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        // Build level 5, then flush colliding with push and pop.
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(0, 1, 'h20 + i, 0, 0, 1, 'h20, i + 1, 0, 1));
        end
        vecs.push_back(mk(0, 1, 'h55, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 'h66, 0, 0, 1, 'h66, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        // Reset mid-stream discards contents.
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(mk(0, 1, 'h90 + i, 0, 0, 1, 'h90, i + 1, 0, 1));
        end
        vecs.push_back(mk(1, 1, 'h93, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h99, 0, 0, 1, 'h99, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));

        foreach (vecs[i]) begin
            reset = vecs[i].rst; rx_ready = vecs[i].rdy; rx_data = vecs[i].d;
            out_ready = vecs[i].ordy; flush = vecs[i].fl;
            @(posedge clock);
            #1;
            check($sformatf("v%0d out_valid", i), int'(out_valid), int'(vecs[i].ev));
            check($sformatf("v%0d level", i), int'(level), vecs[i].el);
            check($sformatf("v%0d empty", i), int'(empty), int'(vecs[i].el == 0));
            check($sformatf("v%0d full", i), int'(full), int'(vecs[i].el == 16));
            check($sformatf("v%0d almost_full", i), int'(almost_full), int'(vecs[i].eaf));
            check($sformatf("v%0d can_receive", i), int'(rx_can_receive_next_word),
                  int'(vecs[i].ecan));
            if (vecs[i].ev) begin
                check($sformatf("v%0d out_data", i), int'(out_data), int'(vecs[i].ed));
            end
        end

        // Wrap-around stream of 0x00..0xFF with random gaps and random consumer stalls.
        reset = 1'b0; rx_ready = 1'b0; out_ready = 1'b0; flush = 1'b0;
        idx = 0; got = 0; mlevel = 0; cyc = 0;
        while (got < 256 && cyc < 20000) begin
            if (!rx_ready && idx < 256 && $urandom_range(0, 3) != 0) begin
                rx_ready = 1'b1;
                rx_data  = word_t'(idx);
            end
            out_ready = (idx < 128) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            #1;
            check("s can_receive", int'(rx_can_receive_next_word), int'(mlevel != 16));
            check("s out_valid", int'(out_valid), int'(mlevel != 0));
            check("s full", int'(full), int'(mlevel == 16));
            check("s level", int'(level), mlevel);
            check("s almost_full", int'(almost_full), int'(mlevel >= 12));
            push_m = rx_ready && (mlevel != 16);
            pop_m  = out_ready && (mlevel != 0);
            if (pop_m) begin
                check($sformatf("s data #%0d", got), int'(out_data), int'(q[0]));
                void'(q.pop_front());
                got++;
            end
            if (push_m) begin
                q.push_back(word_t'(idx));
                idx++;
            end
            mlevel = mlevel + int'(push_m) - int'(pop_m);
            @(posedge clock);
            #1;
            cyc++;
            if (push_m) rx_ready = 1'b0;
        end
        check("s words received", got, 256);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
